mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
Sequencer for a single mac datapath. It computes an N-element dot product by streaming operand pairs over a valid/ready interface. For each element it drives the mac's load, multiply and accumulate enables in sequence, then presents the accumulated sum on a valid/ready result port. It sits between the operand fetch logic and the mac, and is the only driver of the mac's enables.

Parameters:
DATA_W, 8, operand width of a and b
ACC_W, 32, accumulator/result width
LEN_W, 8, width of element-count field (max length 2^LEN_W-1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request new dot product; sampled only in IDLE
len  in  LEN_W  element count, captured with start
abort  in  1  synchronous cancel of the current operation
busy  out  1  high in every state except IDLE
op_valid  in  1  operand pair available
op_ready  out  1  controller accepts operand pair
op_a  in  DATA_W  operand a
op_b  in  DATA_W  operand b
mac_a  out  DATA_W  operand a to mac
mac_b  out  DATA_W  operand b to mac
mac_clr  out  1  clears mac accumulator
mac_load_en  out  1  mac operand-register load
mac_mult_en  out  1  mac multiply stage enable
mac_acc_en  out  1  mac accumulate enable
mac_acc  in  ACC_W  mac accumulator value
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_data  out  ACC_W  captured dot product

Behaviour:
- Reset: state=IDLE; every output is 0, including mac_a, mac_b and res_data; the element counter is 0. Reset mid-operation abandons the operation, and no result is produced.
- FSM states: IDLE, CLEAR, LOAD, MULT, ACC, CAPT, DONE.
- IDLE, start=1: capture len into the remaining counter and go to CLEAR. start is ignored in all other states.
- CLEAR: mac_clr=1 for exactly one cycle. Then go to LOAD if remaining!=0, else to CAPT (len=0 yields result 0).
- LOAD: op_ready=1.
  - mac_load_en = op_valid.
  - mac_a/mac_b driven combinationally from op_a/op_b.
  - On handshake go to MULT; otherwise stay in LOAD with mac_load_en=0.
- MULT: mac_mult_en=1 for one cycle, then go to ACC.
- ACC: mac_acc_en=1 for one cycle and remaining decrements. Next state is LOAD if the decremented count is nonzero, else CAPT.
- CAPT: register mac_acc into res_data, then go to DONE. The value is sampled one cycle after the final acc edge.
- DONE: res_valid=1 and res_data held stable. Go to IDLE on res_ready. res_valid drops the cycle after the handshake.
- Outputs outside their states:
  - op_ready, mac_load_en, mac_mult_en, mac_acc_en and mac_clr are 0.
  - Enables are mutually exclusive in any cycle.
- Latency: with no stalls and start sampled in cycle 0, res_valid first rises in cycle 3N+3. Throughput is one element per 3 cycles.
- abort: in any non-IDLE state other than DONE, go to IDLE next cycle and deassert all enables; res_valid is never raised. In DONE, abort is ignored. abort in IDLE has no effect.
- Simultaneous events:
  - abort together with an op handshake in LOAD: abort wins; the operand is consumed but not multiplied.
  - start together with abort in IDLE: start is taken.
- Width: the counter is LEN_W bits. res_data is exactly mac_acc, with no truncation or saturation; overflow wraps in the mac.

Decomposition:
- mac_seq_pkg holds:
  - the state enum type mac_seq_state_t (7 states);
  - default width constants DATA_W, ACC_W, LEN_W.
- One natural sub-module is mac_len_cnt: a loadable down-counter with load, dec and zero-flag outputs, and an asynchronous reset.
- The FSM and output decode stay in mac_seq_ctrl.

Test Plan:
- len=1, op (5,10) presented immediately, res_ready=1, behavioral mac model → mac_clr in cycle 1; load/mult/acc in cycles 2/3/4; res_valid in cycle 6; res_data=50.
- len=3, ops (1,2),(3,4),(5,6) back-to-back → res_data=44, res_valid in cycle 12, exactly 3 op handshakes.
- len=2, op_valid low for 4 cycles before each pair (7,7),(2,3) → LOAD stalls with all enables 0; res_data=55.
- len=0 → no op_ready; res_valid in cycle 3; res_data=0.
- len=2 (4,4),(1,1), res_ready held low for 5 cycles → res_valid/res_data=17 stable; a start pulse while in DONE is ignored; IDLE follows the handshake.
- Interrupt cases:
  - abort asserted in the second MULT → IDLE next cycle; res_valid never rises; a new len=1 (3,3) yields 9.
  - reset asserted mid-ACC → all outputs 0 asynchronously; busy=0.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the mac sequencer.
package mac_seq_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    MULT,
    ACC,
    CAPT,
    DONE
  } mac_seq_state_t;

endpackage

// File: rtl/mac_len_cnt.sv
// Loadable down-counter tracking how many operand pairs are still to be processed.
module mac_len_cnt #(
  parameter int LEN_W = mac_seq_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [LEN_W-1:0] count_o,
  output logic             zero_o
);
  import mac_seq_pkg::*;

  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_d;

  // Load wins over decrement; the count never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = len_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - LEN_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams operand pairs into a mac and returns the sum.
module mac_seq_ctrl #(
  parameter int DATA_W = mac_seq_pkg::DATA_W,
  parameter int ACC_W  = mac_seq_pkg::ACC_W,
  parameter int LEN_W  = mac_seq_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clr,
  output logic              mac_load_en,
  output logic              mac_mult_en,
  output logic              mac_acc_en,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);
  import mac_seq_pkg::*;

  mac_seq_state_t   state_q;
  mac_seq_state_t   state_d;
  logic [ACC_W-1:0] resData_q;
  logic [ACC_W-1:0] resData_d;
  logic [LEN_W-1:0] remCount;
  logic             remZero;
  logic             cntLoad;
  logic             cntDec;
  logic             lastElem;

  assign cntLoad  = (state_q == IDLE) && start;
  assign cntDec   = (state_q == ACC);
  assign lastElem = (remCount == LEN_W'(1));

  mac_len_cnt #(
    .LEN_W (LEN_W)
  ) u_len_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (cntLoad),
    .dec_i   (cntDec),
    .len_i   (len),
    .count_o (remCount),
    .zero_o  (remZero)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything except IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: state_d = remZero ? CAPT : LOAD;
      LOAD:  if (op_valid) state_d = MULT;
      MULT:  state_d = ACC;
      ACC:   state_d = lastElem ? CAPT : LOAD;
      CAPT:  state_d = DONE;
      DONE:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE) && (state_q != DONE)) begin
      state_d = IDLE;
    end
  end

  // Result register samples the accumulator once, in the cycle after the last accumulate.
  always_comb begin
    resData_d = resData_q;
    if (state_q == CAPT) begin
      resData_d = mac_acc;
    end
  end

  // Result holding register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resData_q <= '0;
    end else begin
      resData_q <= resData_d;
    end
  end

  // Output decode: each mac enable belongs to exactly one state, so they never overlap.
  always_comb begin
    busy        = (state_q != IDLE);
    op_ready    = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
    mac_clr     = 1'b0;
    mac_load_en = 1'b0;
    mac_mult_en = 1'b0;
    mac_acc_en  = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      CLEAR: mac_clr = 1'b1;
      LOAD: begin
        op_ready    = 1'b1;
        mac_load_en = op_valid;
        mac_a       = op_a;
        mac_b       = op_b;
      end
      MULT:  mac_mult_en = 1'b1;
      ACC:   mac_acc_en  = 1'b1;
      DONE:  res_valid   = 1'b1;
      default: begin
      end
    endcase
  end

  assign res_data = resData_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural mac and a dot-product reference.
module tb_mac_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              abort = 1'b0;
  logic              busy;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [DATA_W-1:0] op_a = '0;
  logic [DATA_W-1:0] op_b = '0;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic              mac_clr;
  logic              mac_load_en;
  logic              mac_mult_en;
  logic              mac_acc_en;
  logic [ACC_W-1:0]  mac_acc;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [ACC_W-1:0]  res_data;

  logic [DATA_W-1:0] modelA;
  logic [DATA_W-1:0] modelB;
  logic [ACC_W-1:0]  modelProd;
  logic [ACC_W-1:0]  modelAcc;

  int checkCount = 0;
  int failCount  = 0;
  int hsCount    = 0;

  logic [DATA_W-1:0] opsA [256];
  logic [DATA_W-1:0] opsB [256];
  int                stalls [256];

  mac_seq_ctrl #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .abort       (abort),
    .busy        (busy),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_clr     (mac_clr),
    .mac_load_en (mac_load_en),
    .mac_mult_en (mac_mult_en),
    .mac_acc_en  (mac_acc_en),
    .mac_acc     (mac_acc),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural mac: operand registers, multiply stage and accumulator.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      modelA    <= '0;
      modelB    <= '0;
      modelProd <= '0;
      modelAcc  <= '0;
    end else begin
      if (mac_clr) modelAcc <= '0;
      if (mac_load_en) begin
        modelA <= mac_a;
        modelB <= mac_b;
      end
      if (mac_mult_en) modelProd <= 32'(modelA) * 32'(modelB);
      if (mac_acc_en) modelAcc <= modelAcc + modelProd;
    end
  end

  assign mac_acc = modelAcc;

  // Operand handshake counter.
  always @(posedge clk) begin
    if (!reset && op_valid && op_ready) hsCount++;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  // The mac enables must never overlap.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      checkOutput("enables_onehot0", 32'($onehot0({mac_clr, mac_load_en, mac_mult_en, mac_acc_en})), 32'd1);
    end
  end

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One complete dot product using opsA/opsB/stalls; the reference is the plain sum of products.
  task automatic applyStimulus(input string tag, input int n, input int readyDelay, input bit abortWithStart);
    logic [31:0] expSum;
    int expCyc, budget, cyc, idx, waited, readyWait, firstValid, firstLoad, clrCount, clrCyc;
    bit pending, finished;
    expSum = 0;
    expCyc = 3 + 3 * n;
    for (int i = 0; i < n; i++) begin
      expSum += 32'(opsA[i]) * 32'(opsB[i]);
      expCyc += stalls[i];
    end
    budget = expCyc + readyDelay + 20;
    idx = 0; waited = 0; readyWait = 0; firstValid = -1; firstLoad = -1;
    clrCount = 0; clrCyc = -1; finished = 0;
    hsCount = 0;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(n);
    abort = abortWithStart;
    @(posedge clk);
    cyc = 1;
    while (!finished && budget > 0) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; op_valid = 1'b0; res_ready = 1'b0; pending = 0;
      op_a = DATA_W'($urandom);
      op_b = DATA_W'($urandom);
      if (op_ready && idx < n) begin
        if (waited < stalls[idx]) begin
          waited++;
        end else begin
          op_valid = 1'b1;
          op_a     = opsA[idx];
          op_b     = opsB[idx];
          pending  = 1;
        end
      end
      if (res_valid) begin
        if (firstValid < 0) firstValid = cyc;
        if (readyWait < readyDelay) begin
          checkOutput({tag, " hold_data"}, res_data, expSum);
          if (readyWait == 1) begin
            start = 1'b1;
            abort = 1'b1;
          end
          readyWait++;
        end else begin
          checkOutput({tag, " res_data"}, res_data, expSum);
          res_ready = 1'b1;
          finished  = 1;
        end
      end
      #1;
      if (mac_clr) begin
        clrCount++;
        clrCyc = cyc;
      end
      if (mac_load_en && firstLoad < 0) firstLoad = cyc;
      if (pending) begin
        checkOutput({tag, " mac_a"}, 32'(mac_a), 32'(opsA[idx]));
        checkOutput({tag, " mac_b"}, 32'(mac_b), 32'(opsB[idx]));
      end
      @(posedge clk);
      if (pending) begin
        idx++;
        waited = 0;
      end
      cyc++;
      budget--;
    end
    if (!finished) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
      pulseReset();
      return;
    end
    checkOutput({tag, " valid_cycle"}, 32'(firstValid), 32'(expCyc));
    checkOutput({tag, " clr_count"}, 32'(clrCount), 32'd1);
    checkOutput({tag, " clr_cycle"}, 32'(clrCyc), 32'd1);
    checkOutput({tag, " handshakes"}, 32'(hsCount), 32'(n));
    checkOutput({tag, " first_load"}, 32'(firstLoad), (n > 0) ? 32'(2 + stalls[0]) : 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    checkOutput({tag, " idle_after"}, 32'({busy, res_valid}), 32'd0);
  endtask

  // Abort a len=3 job: mode 0 in the second MULT, mode 1 together with the second operand handshake.
  task automatic applyAbort(input string tag, input int mode);
    int budget, idx, multSeen;
    bit aborted, pending;
    budget = 60; idx = 0; multSeen = 0; aborted = 0;
    hsCount = 0;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(3);
    @(posedge clk);
    while (!aborted && budget > 0) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; op_valid = 1'b0; pending = 0;
      if (mac_mult_en) multSeen++;
      if (op_ready && idx < 3) begin
        op_valid = 1'b1;
        op_a     = DATA_W'($urandom);
        op_b     = DATA_W'($urandom);
        pending  = 1;
        if (mode == 1 && idx == 1) begin
          abort   = 1'b1;
          aborted = 1;
        end
      end
      if (mode == 0 && mac_mult_en && multSeen == 2) begin
        abort   = 1'b1;
        aborted = 1;
      end
      @(posedge clk);
      if (pending) idx++;
      budget--;
    end
    if (!aborted) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
      pulseReset();
      return;
    end
    @(negedge clk);
    abort = 1'b0;
    op_valid = 1'b0;
    #1;
    checkOutput({tag, " busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, " outs_after"},
                32'({op_ready, mac_clr, mac_load_en, mac_mult_en, mac_acc_en, res_valid}), 32'd0);
    if (mode == 1) checkOutput({tag, " handshakes"}, 32'(hsCount), 32'd2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      checkOutput({tag, " stays_idle"}, 32'({res_valid, busy}), 32'd0);
    end
  endtask

  // Assert reset while the controller sits in ACC; everything must drop at once.
  task automatic applyReset(input string tag);
    int budget;
    bit seen;
    budget = 40; seen = 0;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(2);
    @(posedge clk);
    while (!seen && budget > 0) begin
      @(negedge clk);
      start    = 1'b0;
      op_valid = op_ready;
      op_a     = DATA_W'($urandom_range(1, 255));
      op_b     = DATA_W'($urandom_range(1, 255));
      #1;
      if (mac_acc_en) seen = 1;
      else @(posedge clk);
      budget--;
    end
    if (!seen) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
      pulseReset();
      return;
    end
    op_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " ctrl_outs"},
                32'({op_ready, mac_clr, mac_load_en, mac_mult_en, mac_acc_en, res_valid}), 32'd0);
    checkOutput({tag, " mac_ab"}, 32'({mac_a, mac_b}), 32'd0);
    checkOutput({tag, " res_data"}, res_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic setOp(input int i, input int a, input int b, input int s);
    opsA[i]   = DATA_W'(a);
    opsB[i]   = DATA_W'(b);
    stalls[i] = s;
  endtask

  // Directed plan followed by randomized jobs.
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ctrl_outs",
                32'({op_ready, mac_clr, mac_load_en, mac_mult_en, mac_acc_en, res_valid}), 32'd0);
    checkOutput("reset mac_ab", 32'({mac_a, mac_b}), 32'd0);
    checkOutput("reset res_data", res_data, 32'd0);

    setOp(0, 5, 10, 0);
    applyStimulus("len1", 1, 0, 0);

    setOp(0, 1, 2, 0); setOp(1, 3, 4, 0); setOp(2, 5, 6, 0);
    applyStimulus("len3", 3, 0, 0);

    setOp(0, 7, 7, 4); setOp(1, 2, 3, 4);
    applyStimulus("stall", 2, 0, 0);

    applyStimulus("len0", 0, 0, 0);

    setOp(0, 4, 4, 0); setOp(1, 1, 1, 0);
    applyStimulus("res_hold", 2, 5, 0);

    applyAbort("abort_mult", 0);
    setOp(0, 3, 3, 0);
    applyStimulus("after_abort", 1, 0, 0);

    applyAbort("abort_load", 1);
    setOp(0, 200, 17, 1);
    applyStimulus("after_abort2", 1, 0, 0);

    applyReset("reset_acc");
    setOp(0, 255, 255, 0);
    applyStimulus("after_reset", 1, 0, 0);

    setOp(0, 9, 8, 0); setOp(1, 6, 5, 0);
    applyStimulus("start_abort_idle", 2, 0, 1);

    for (int i = 0; i < 255; i++) setOp(i, $urandom, $urandom, 0);
    applyStimulus("len_max", 255, 0, 0);

    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        setOp(i, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      applyStimulus("random", n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
